cfg_bank: RTL and testbench
===========================

# cfg_bank

Parametrised configuration register bank for the PI-bus control plane. It replaces fixed per-field config decoding with NREG registers of DW bits each. Registers are double-buffered: MCU writes land in a shadow bank and are committed to the active bank atomically, either immediately or at the next `sync_pulse` (e.g. vblank), with a timeout fallback. Selected registers bypass the shadow. Active values drive the cartridge, audio and mapper logic through `cfg_q`.

## Interface
Parameters:
- NREG, 8, number of config registers (≥2)
- DW, 8, register width in bits (≥3)
- AW, $clog2(NREG), register index width (derived; not overridden)
- RST_VAL, 0, NREG*DW packed reset value; register i is at [i*DW +: DW]
- BYPASS_MASK, 0, NREG bits; bit i=1 means register i writes straight to active (no shadow)
- SYNC_TIMEOUT, 1048576, cycles to wait for `sync_pulse` before a forced commit; 0 disables the timeout
- TW, 24, timeout counter width (must hold SYNC_TIMEOUT)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- pi_addr  in  AW+1  bit AW: 0 = data space, 1 = control space; [AW-1:0] = index
- pi_dato  in  DW  write data
- pi_we  in  1  single-cycle, clk-synchronous write strobe
- pi_ce  in  1  bank chip-enable; a write happens only when `pi_we & pi_ce`
- sync_pulse  in  1  single-cycle safe-commit point
- rd_data  out  DW  registered readback of `pi_addr`
- cfg_q  out  NREG*DW  active register values
- commit_stb  out  1  one-cycle pulse when the active bank is loaded from the shadow
- pending  out  1  a sync-commit is armed
- dirty  out  1  shadow differs from active by write history since the last commit or revert

## Operation
- Data write, index < NREG, non-bypass: shadow[i] ← pi_dato; dirty ← 1.
- Data write, bypass register: shadow[i] and active[i] ← pi_dato. `dirty` is unchanged. No `commit_stb`.
- Data write, index ≥ NREG: ignored.
- Control index 0 (CTRL), on write. Bits are evaluated with this priority:
  - bit2 REVERT: shadow ← active; pending ← 0; dirty ← 0.
  - bit0 COMMIT_NOW: active ← shadow; pending ← 0; dirty ← 0; `commit_stb` pulses.
  - bit1 COMMIT_SYNC: pending ← 1. If already pending, the timeout counter is not restarted.
  - All three bits zero: no-op.
- Other control indices: writes ignored.
- Timeout counter: cleared when pending is 0. Increments each cycle while pending. When `pending` and (`sync_pulse` or counter == SYNC_TIMEOUT-1):
  - active ← shadow; pending ← 0; dirty ← 0; `commit_stb` pulses.
- Readback:
  - Data index < NREG returns shadow[i].
  - Control index 0 returns STATUS: bit0 = pending, bit1 = dirty, other bits 0.
  - All other addresses return 0.
- Commits always copy all non-bypass registers at once. Bypass registers are never touched by commit or revert (their shadow always equals active).

## Timing
- Reset (rst=0 at an edge): shadow = active = RST_VAL; pending, dirty, commit_stb, counter, rd_data all 0. Any write in the same cycle is discarded.
- Write at edge t: shadow and bypass active visible at t+1. COMMIT_NOW at t: `cfg_q` updates at t+1 and `commit_stb`=1 during t+1 only.
- Sync commit: `sync_pulse` at t with pending=1 gives `cfg_q` and `commit_stb` at t+1.
- Arm latency: a COMMIT_SYNC write in the same cycle as `sync_pulse` does not commit. pending=1 at t+1, and the commit waits for the next pulse.
- Simultaneous data write and commit (sync, timeout or COMMIT_NOW) in one cycle:
  - The commit copies the pre-write shadow.
  - The new value lands in shadow only, and dirty = 1 afterwards.
- rd_data latency: 1 cycle (rd_data at t+1 reflects pi_addr and state sampled at t). A write and a read of the same register in one cycle return the old value.
- Timeout: pending set at t, with no `sync_pulse`, gives the commit at t+SYNC_TIMEOUT.
- `commit_stb` is never high two consecutive cycles from one event. A new event in the following cycle can pulse again.

## Test plan
- Reset: RST_VAL with reg0=0x15, reg1=0xFF; hold rst=0 for 2 cycles while writing -> `cfg_q` equals RST_VAL, rd_data=0, pending=dirty=0.
- Shadow commit: write reg2=0xA5 -> `cfg_q` reg2 unchanged, readback 0xA5, dirty=1. Then CTRL=0x01 -> reg2=0xA5 at the next cycle, `commit_stb` one cycle, dirty=0.
- Sync vs timeout, SYNC_TIMEOUT=16:
  - Write reg3=0x3C, CTRL=0x02, pulse `sync_pulse` 5 cycles later -> commit at +1, pending=0.
  - Repeat without a pulse -> forced commit exactly 16 cycles after arming.
- Same-cycle conflicts:
  - COMMIT_SYNC write coincident with `sync_pulse` -> no commit until the next pulse.
  - Data write reg4=0x77 coincident with `sync_pulse` -> active reg4 keeps its old value, shadow=0x77, dirty=1.
- Bypass and revert, BYPASS_MASK bit5=1:
  - Write reg5=0x80 -> `cfg_q` reg5=0x80 next cycle, no `commit_stb`, dirty unchanged.
  - Write reg1=0x11, then CTRL=0x07 -> revert wins: reg1 readback returns the active value, pending=dirty=0, no `commit_stb`.
- Address edges, NREG=6: write index 7 and control index 3 -> no state change, both read 0. STATUS read while pending returns 0x01 or 0x03.

Source files
------------

// File: rtl/cfg_bank.sv
// Double-buffered configuration register bank: MCU writes land in a shadow copy
// and are committed to the active copy immediately, on sync_pulse, or on timeout.

module cfg_bank_reg #(
  parameter int           DW     = 8,
  parameter bit           BYPASS = 1'b0,
  parameter logic [DW-1:0] RST   = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          commit_i,
  input  logic          revert_i,
  output logic [DW-1:0] shadow_o,
  output logic [DW-1:0] active_o
);
  logic [DW-1:0] shadow_q, shadow_d, active_q, active_d;

  // Commit/revert act on the pre-write copies; a same-cycle write then lands in shadow.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (BYPASS) begin
      if (wr_i) begin
        shadow_d = wdata_i;
        active_d = wdata_i;
      end
    end else begin
      if (revert_i) shadow_d = active_q;
      if (commit_i) active_d = shadow_q;
      if (wr_i)     shadow_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q <= RST;
      active_q <= RST;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;
endmodule

module cfg_bank #(
  parameter int                   NREG         = 8,
  parameter int                   DW           = 8,
  parameter int                   AW           = $clog2(NREG),
  parameter logic [NREG*DW-1:0]   RST_VAL      = '0,
  parameter logic [NREG-1:0]      BYPASS_MASK  = '0,
  parameter int                   SYNC_TIMEOUT = 1048576,
  parameter int                   TW           = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW:0]        pi_addr,
  input  logic [DW-1:0]      pi_dato,
  input  logic               pi_we,
  input  logic               pi_ce,
  input  logic               sync_pulse,
  output logic [DW-1:0]      rd_data,
  output logic [NREG*DW-1:0] cfg_q,
  output logic               commit_stb,
  output logic               pending,
  output logic               dirty
);
  localparam logic [AW:0]   NREG_W   = (AW+1)'(NREG);
  localparam logic [TW-1:0] TMO_LAST = TW'(SYNC_TIMEOUT - 1);

  logic [NREG-1:0][DW-1:0] shadow_w, active_w;
  logic [NREG-1:0]         wr_sel;
  logic [AW-1:0]           idx;
  logic                    wr, is_ctrl, idx_ok, data_wr, ctrl_wr;
  logic                    revert, cnow, csync, tmo_hit, commit;

  logic          pending_q, pending_d, dirty_q, dirty_d, stb_q;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rd_q, rd_d;

  assign wr      = pi_we & pi_ce;
  assign is_ctrl = pi_addr[AW];
  assign idx     = pi_addr[AW-1:0];
  assign idx_ok  = {1'b0, idx} < NREG_W;
  assign data_wr = wr & ~is_ctrl & idx_ok;
  assign ctrl_wr = wr & is_ctrl & (idx == '0);

  // CTRL priority: REVERT > COMMIT_NOW > COMMIT_SYNC.
  assign revert  = ctrl_wr & pi_dato[2];
  assign cnow    = ctrl_wr & ~pi_dato[2] & pi_dato[0];
  assign csync   = ctrl_wr & ~pi_dato[2] & ~pi_dato[0] & pi_dato[1];
  assign tmo_hit = (SYNC_TIMEOUT != 0) && (cnt_q == TMO_LAST);
  assign commit  = cnow | (pending_q & (sync_pulse | tmo_hit) & ~revert);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    assign wr_sel[gi] = data_wr && (idx == AW'(gi));
    cfg_bank_reg #(
      .DW     (DW),
      .BYPASS (BYPASS_MASK[gi]),
      .RST    (RST_VAL[gi*DW +: DW])
    ) u_reg (
      .clk      (clk),
      .rst      (rst),
      .wr_i     (wr_sel[gi]),
      .wdata_i  (pi_dato),
      .commit_i (commit),
      .revert_i (revert),
      .shadow_o (shadow_w[gi]),
      .active_o (active_w[gi])
    );
  end

  always_comb begin
    pending_d = pending_q;
    dirty_d   = dirty_q;
    if (revert || commit) begin
      pending_d = 1'b0;
      dirty_d   = 1'b0;
    end
    if (csync) pending_d = 1'b1;
    if (|(wr_sel & ~BYPASS_MASK)) dirty_d = 1'b1;
    // Re-arming while already pending keeps counting; a fresh arm starts at zero.
    cnt_d = (pending_q && pending_d && !commit) ? cnt_q + TW'(1) : '0;
  end

  always_comb begin
    rd_d = '0;
    if (!is_ctrl) begin
      for (int i = 0; i < NREG; i++)
        if (idx == AW'(i)) rd_d = shadow_w[i];
    end else if (idx == '0) begin
      rd_d[0] = pending_q;
      rd_d[1] = dirty_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q <= 1'b0;
      dirty_q   <= 1'b0;
      stb_q     <= 1'b0;
      cnt_q     <= '0;
      rd_q      <= '0;
    end else begin
      pending_q <= pending_d;
      dirty_q   <= dirty_d;
      stb_q     <= commit;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
    end
  end

  assign cfg_q      = active_w;
  assign rd_data    = rd_q;
  assign commit_stb = stb_q;
  assign pending    = pending_q;
  assign dirty      = dirty_q;
endmodule

// File: tb/tb_cfg_bank.sv
// Directed vector bench for cfg_bank: NREG=6, reg5 bypass, 16-cycle sync timeout.

module tb_cfg_bank;
  localparam int NREG = 6;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam logic [47:0] R  = 48'h0000_0000_FF15;
  localparam logic [47:0] C1 = 48'h0000_00A5_FF15;
  localparam logic [47:0] C2 = 48'h0000_3CA5_FF15;
  localparam logic [47:0] C3 = 48'h0000_5AA5_FF15;
  localparam logic [47:0] C4 = 48'h0000_5AA5_FF21;
  localparam logic [47:0] C5 = 48'h8000_5AA5_FF21;
  localparam logic [47:0] C6 = 48'h8000_5A42_FF21;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   pi_addr;
  logic [DW-1:0] pi_dato;
  logic          pi_we, pi_ce, sync_pulse;
  logic [DW-1:0] rd_data;
  logic [47:0]   cfg_q;
  logic          commit_stb, pending, dirty;

  int checks = 0;
  int errors = 0;

  cfg_bank #(
    .NREG         (NREG),
    .DW           (DW),
    .RST_VAL      (R),
    .BYPASS_MASK  (6'b100000),
    .SYNC_TIMEOUT (16),
    .TW           (24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pi_addr    (pi_addr),
    .pi_dato    (pi_dato),
    .pi_we      (pi_we),
    .pi_ce      (pi_ce),
    .sync_pulse (sync_pulse),
    .rd_data    (rd_data),
    .cfg_q      (cfg_q),
    .commit_stb (commit_stb),
    .pending    (pending),
    .dirty      (dirty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, we, ce;
    logic [3:0]  a;
    logic [7:0]  d;
    logic        sp;
    logic [47:0] cfg;
    logic [7:0]  rd;
    logic        stb, p, dy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, we, ce, input logic [3:0] a, input logic [7:0] d,
                             input logic sp, input logic [47:0] cfg, input logic [7:0] rd,
                             input logic stb, p, dy);
    vec_t x;
    x.r = r; x.we = we; x.ce = ce; x.a = a; x.d = d; x.sp = sp;
    x.cfg = cfg; x.rd = rd; x.stb = stb; x.p = p; x.dy = dy;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, we, ce, input logic [3:0] a, input logic [7:0] d,
                       input logic sp);
    @(negedge clk);
    rst = r; pi_we = we; pi_ce = ce; pi_addr = a; pi_dato = d; sync_pulse = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t x;
    x = tbl[i];
    drive(x.r, x.we, x.ce, x.a, x.d, x.sp);
    chk($sformatf("v%0d cfg_q", i), {16'h0, cfg_q}, {16'h0, x.cfg});
    chk($sformatf("v%0d rd_data", i), {56'h0, rd_data}, {56'h0, x.rd});
    chk($sformatf("v%0d commit_stb", i), {63'h0, commit_stb}, {63'h0, x.stb});
    chk($sformatf("v%0d pending", i), {63'h0, pending}, {63'h0, x.p});
    chk($sformatf("v%0d dirty", i), {63'h0, dirty}, {63'h0, x.dy});
  endtask

  initial begin
    int n1;
    rst = 1'b0; pi_we = 1'b0; pi_ce = 1'b0; pi_addr = '0; pi_dato = '0; sync_pulse = 1'b0;

    // reset held with writes, shadow commit, sync commit
    tbl.push_back(v(0,1,1,4'h0,8'hAA,0, R, 8'h00,0,0,0));
    tbl.push_back(v(0,1,1,4'h2,8'hBB,0, R, 8'h00,0,0,0));
    tbl.push_back(v(1,0,0,4'h0,8'h00,0, R, 8'h15,0,0,0));
    tbl.push_back(v(1,1,1,4'h2,8'hA5,0, R, 8'h00,0,0,1));
    tbl.push_back(v(1,0,0,4'h2,8'h00,0, R, 8'hA5,0,0,1));
    tbl.push_back(v(1,1,1,4'h8,8'h01,0, C1,8'h02,1,0,0));
    tbl.push_back(v(1,0,0,4'h8,8'h00,0, C1,8'h00,0,0,0));
    tbl.push_back(v(1,1,1,4'h3,8'h3C,0, C1,8'h00,0,0,1));
    tbl.push_back(v(1,1,1,4'h8,8'h02,0, C1,8'h02,0,1,1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(v(1,0,0,4'h8,8'h00,0, C1,8'h03,0,1,1));
    tbl.push_back(v(1,0,0,4'h8,8'h00,1, C2,8'h03,1,0,0));
    tbl.push_back(v(1,0,0,4'h8,8'h00,0, C2,8'h00,0,0,0));
    n1 = tbl.size();

    // same-cycle conflicts
    tbl.push_back(v(1,1,1,4'h0,8'h21,0, C3,8'h15,0,0,1));
    tbl.push_back(v(1,1,1,4'h8,8'h02,1, C3,8'h02,0,1,1));
    tbl.push_back(v(1,0,0,4'h8,8'h00,0, C3,8'h03,0,1,1));
    tbl.push_back(v(1,0,0,4'h8,8'h00,1, C4,8'h03,1,0,0));
    tbl.push_back(v(1,1,1,4'h8,8'h02,0, C4,8'h00,0,1,0));
    tbl.push_back(v(1,1,1,4'h4,8'h77,1, C4,8'h00,1,0,1));
    tbl.push_back(v(1,0,0,4'h4,8'h00,0, C4,8'h77,0,0,1));
    // bypass and revert
    tbl.push_back(v(1,1,1,4'h5,8'h80,0, C5,8'h00,0,0,1));
    tbl.push_back(v(1,0,0,4'h5,8'h00,0, C5,8'h80,0,0,1));
    tbl.push_back(v(1,1,1,4'h1,8'h11,0, C5,8'hFF,0,0,1));
    tbl.push_back(v(1,1,1,4'h8,8'h07,0, C5,8'h02,0,0,0));
    tbl.push_back(v(1,0,0,4'h1,8'h00,0, C5,8'hFF,0,0,0));
    tbl.push_back(v(1,0,0,4'h4,8'h00,0, C5,8'h00,0,0,0));
    tbl.push_back(v(1,0,0,4'h5,8'h00,0, C5,8'h80,0,0,0));
    // address edges and chip-enable gating
    tbl.push_back(v(1,1,1,4'h7,8'hEE,0, C5,8'h00,0,0,0));
    tbl.push_back(v(1,1,1,4'hB,8'h03,0, C5,8'h00,0,0,0));
    tbl.push_back(v(1,0,0,4'hB,8'h00,0, C5,8'h00,0,0,0));
    tbl.push_back(v(1,1,0,4'h0,8'h33,0, C5,8'h21,0,0,0));
    tbl.push_back(v(1,0,0,4'h0,8'h00,0, C5,8'h21,0,0,0));
    // STATUS while pending, back-to-back COMMIT_NOW
    tbl.push_back(v(1,1,1,4'h8,8'h02,0, C5,8'h00,0,1,0));
    tbl.push_back(v(1,0,0,4'h8,8'h00,0, C5,8'h01,0,1,0));
    tbl.push_back(v(1,1,1,4'h2,8'h42,0, C5,8'hA5,0,1,1));
    tbl.push_back(v(1,0,0,4'h8,8'h00,0, C5,8'h03,0,1,1));
    tbl.push_back(v(1,1,1,4'h8,8'h01,0, C6,8'h03,1,0,0));
    tbl.push_back(v(1,1,1,4'h8,8'h01,0, C6,8'h00,1,0,0));
    tbl.push_back(v(1,0,0,4'h8,8'h00,0, C6,8'h00,0,0,0));

    for (int i = 0; i < n1; i++) run_vec(i);

    // timeout: arm at edge t, no pulse, forced commit exactly at edge t+16
    drive(1,1,1,4'h3,8'h5A,0);
    chk("tmo write dirty", {63'h0, dirty}, 64'h1);
    chk("tmo write cfg_q", {16'h0, cfg_q}, {16'h0, C2});
    drive(1,1,1,4'h8,8'h02,0);
    chk("tmo arm pending", {63'h0, pending}, 64'h1);
    for (int k = 1; k < 16; k++) begin
      drive(1,0,0,4'h0,8'h00,0);
      chk($sformatf("tmo +%0d stb", k), {63'h0, commit_stb}, 64'h0);
      chk($sformatf("tmo +%0d pending", k), {63'h0, pending}, 64'h1);
      chk($sformatf("tmo +%0d cfg_q", k), {16'h0, cfg_q}, {16'h0, C2});
    end
    drive(1,0,0,4'h0,8'h00,0);
    chk("tmo +16 stb", {63'h0, commit_stb}, 64'h1);
    chk("tmo +16 cfg_q", {16'h0, cfg_q}, {16'h0, C3});
    chk("tmo +16 pending", {63'h0, pending}, 64'h0);
    chk("tmo +16 dirty", {63'h0, dirty}, 64'h0);
    drive(1,0,0,4'h0,8'h00,0);
    chk("tmo +17 stb", {63'h0, commit_stb}, 64'h0);

    for (int i = n1; i < tbl.size(); i++) run_vec(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
